sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
// - Conditioning stage directly upstream of the fpga top-level logic: takes the raw, asynchronous, bouncing SW
//   switch and delivers a clean level plus one-cycle edge pulses to the LED_ROUGE/LED_VERTE control logic.
// - 2+ flop synchronizer, then a counter-qualified debounce FSM; a toggle output gives push-button-style control.
// PARAMETERS
// - CLK_FREQ_HZ   50_000_000  CLK frequency (50 MHz board clock)
// - DEBOUNCE_US   10_000      required stable time in us; CNT_MAX = CLK_FREQ_HZ/1_000_000*DEBOUNCE_US cycles
// - SYNC_STAGES   2           synchronizer depth, legal range >= 2
// PORTS
// - CLK        in   1  system clock, all flops on posedge
// - RST        in   1  asynchronous reset, active-high; deassertion is synchronous to CLK at the top level
// - SW         in   1  raw switch, asynchronous to CLK, may bounce
// - SW_DB      out  1  debounced level
// - SW_RISE    out  1  one-cycle pulse when SW_DB goes 0->1
// - SW_FALL    out  1  one-cycle pulse when SW_DB goes 1->0
// - SW_TOGGLE  out  1  inverts on every SW_RISE
// BEHAVIOUR
// - Reset (RST=1, asynchronous): synchronizer flops=0, counter=0, state=ST_LO, SW_DB=0, SW_RISE=0, SW_FALL=0,
//   SW_TOGGLE=0. Every output is a registered value; none is combinational from SW.
// - Synchronized sample s = last stage of the SYNC_STAGES chain. s follows SW after SYNC_STAGES posedges.
// - Elaboration check: CNT_MAX >= 1, else $error. Counter width = $clog2(CNT_MAX+1).
// - FSM states: ST_LO, ST_PEND_HI, ST_HI, ST_PEND_LO. SW_DB = 1 in ST_HI and ST_PEND_LO, else 0.
//   - ST_LO: s=1 -> ST_PEND_HI with cnt=1 (CNT_MAX=1: go straight to ST_HI and fire SW_RISE). s=0 -> stay, cnt=0.
//   - ST_PEND_HI: s=0 -> ST_LO, cnt=0 (a bounce aborts the pending change, no pulse).
//     s=1 and cnt==CNT_MAX-1 -> ST_HI, cnt=0, SW_RISE=1 for one cycle, SW_TOGGLE inverts. Else cnt++.
//   - ST_HI / ST_PEND_LO: mirror of the above with polarity swapped; completion fires SW_FALL, no toggle change.
// - The counter counts consecutive cycles of s != SW_DB; any single agreeing cycle clears it.
//   It never wraps: the maximum value is CNT_MAX-1 before the state change.
// - Latency: a clean SW step propagates to SW_DB, and to its pulse, after exactly SYNC_STAGES+CNT_MAX posedges.
// - Pulses are mutually exclusive and at least CNT_MAX cycles apart. SW_TOGGLE changes only together with SW_RISE.
// - Pulses shorter than CNT_MAX cycles at s are ignored completely.
// - RST asserted mid-count: pending state is discarded immediately. After release the block restarts from ST_LO.
//   If SW is held high through reset, SW_RISE fires SYNC_STAGES+CNT_MAX cycles after release.
// STRUCTURE
// - Package sw_debounce_pkg:
//   - typedef enum logic [1:0] {ST_LO, ST_PEND_HI, ST_HI, ST_PEND_LO} db_state_t
//   - function automatic int cnt_max(int f_hz, int us) for the cycle-count computation
// - Sub-module sync_ff #(STAGES) (CLK, RST, d, q): generic N-flop synchronizer, reused for other board inputs.
// - sw_debounce holds one always_ff for the FSM, counter and outputs, and one always_comb for the next state.
// TESTING (bench uses CLK_FREQ_HZ=50_000_000, DEBOUNCE_US=1 -> CNT_MAX=50, SYNC_STAGES=2)
// - Reset: RST=1 with SW=1 for 5 cycles -> all outputs 0. Release -> SW_DB=1 and a single SW_RISE at cycle 52.
// - Clean step: SW 0->1 held -> SW_DB rises 52 posedges later; SW_RISE=1 for exactly 1 cycle; SW_TOGGLE=1.
// - Bounce: SW toggles every 7 cycles for 300 cycles, then stays 0 -> SW_DB stays 0; SW_RISE/SW_FALL never fire.
// - Near-threshold: s high for 49 cycles, then low -> no change. s high for 50 cycles -> SW_DB=1 and one SW_RISE.
// - Toggle: 3 clean press/release cycles -> 3 SW_RISE, 3 SW_FALL; SW_TOGGLE sequence 1,0,1.
// - Reset mid-count: RST pulsed at cnt=30 in ST_PEND_HI -> state ST_LO and cnt=0 at once; no spurious pulse.
//   Random SW per cycle for 1000 cycles -> assertions hold: pulses one-hot, SW_DB edge <=> pulse.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and helpers for the switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [1:0] {ST_LO, ST_PEND_HI, ST_HI, ST_PEND_LO} db_state_t;

  // Number of CLK cycles the synchronized switch must stay stable
  function automatic int cnt_max(int f_hz, int us);
    return (f_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/sw_debounce_sync.sv
// Generic N-flop synchronizer for asynchronous board inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be >= 2");
  end

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning: synchronizer, counter-qualified debounce FSM, edge pulses and toggle.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 50_000_000,
  parameter int          DEBOUNCE_US = 10_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW,
  output logic SW_DB,
  output logic SW_RISE,
  output logic SW_FALL,
  output logic SW_TOGGLE
);

  localparam int          CNT_MAX  = cnt_max(CLK_FREQ_HZ, DEBOUNCE_US);
  localparam int unsigned CNT_W    = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  if (CNT_MAX < 1) begin : g_bad_cnt
    $error("sw_debounce: CNT_MAX must be >= 1");
  end

  logic             s;
  db_state_t        state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             rise_nx, fall_nx, db_nx;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (SW),
    .q   (s)
  );

  // Next state: count consecutive disagreeing samples, any agreeing sample aborts
  always_comb begin
    state_nx = state_q;
    cnt_nx   = '0;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state_q)
      ST_LO: begin
        if (s) begin
          if (CNT_MAX == 1) begin
            state_nx = ST_HI;
            rise_nx  = 1'b1;
          end else begin
            state_nx = ST_PEND_HI;
            cnt_nx   = CNT_W'(1);
          end
        end
      end
      ST_PEND_HI: begin
        if (!s) begin
          state_nx = ST_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_nx = ST_HI;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!s) begin
          if (CNT_MAX == 1) begin
            state_nx = ST_LO;
            fall_nx  = 1'b1;
          end else begin
            state_nx = ST_PEND_LO;
            cnt_nx   = CNT_W'(1);
          end
        end
      end
      ST_PEND_LO: begin
        if (s) begin
          state_nx = ST_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_nx = ST_LO;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      default: state_nx = ST_LO;
    endcase
    db_nx = (state_nx == ST_HI) || (state_nx == ST_PEND_LO);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_LO;
      cnt_q     <= '0;
      SW_DB     <= 1'b0;
      SW_RISE   <= 1'b0;
      SW_FALL   <= 1'b0;
      SW_TOGGLE <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      SW_DB     <= db_nx;
      SW_RISE   <= rise_nx;
      SW_FALL   <= fall_nx;
      SW_TOGGLE <= SW_TOGGLE ^ rise_nx;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with CNT_MAX=50, SYNC_STAGES=2.
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int CNT_MAX = 50;
  localparam int LAT     = 52;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SW  = 1'b1;
  logic SW_DB, SW_RISE, SW_FALL, SW_TOGGLE;

  int n_tests = 0;
  int n_fail  = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int viol     = 0;

  sw_debounce #(
    .CLK_FREQ_HZ (50_000_000),
    .DEBOUNCE_US (1),
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW        (SW),
    .SW_DB     (SW_DB),
    .SW_RISE   (SW_RISE),
    .SW_FALL   (SW_FALL),
    .SW_TOGGLE (SW_TOGGLE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Count negedges until the selected pulse appears; -1 if it never does
  task automatic wait_pulse(input bit rise, input int max, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < max) begin
      @(negedge CLK);
      n++;
      seen = rise ? SW_RISE : SW_FALL;
    end
    if (!seen) n = -1;
  endtask

  // Invariant monitor: pulse/edge pairing, one-hot pulses, toggle, spacing
  logic prev_db  = 1'b0;
  logic prev_tog = 1'b0;
  int   since    = 1000;
  always begin
    @(posedge CLK);
    #1;
    if (RST) begin
      prev_db  = 1'b0;
      prev_tog = 1'b0;
      since    = 1000;
    end else begin
      since++;
      if (SW_RISE && SW_FALL) viol++;
      if ((SW_DB && !prev_db) != SW_RISE) viol++;
      if ((!SW_DB && prev_db) != SW_FALL) viol++;
      if ((SW_TOGGLE != prev_tog) != SW_RISE) viol++;
      if (SW_RISE || SW_FALL) begin
        if (since < CNT_MAX) viol++;
        since = 0;
        if (SW_RISE) rise_cnt++;
        else         fall_cnt++;
      end
      prev_db  = SW_DB;
      prev_tog = SW_TOGGLE;
    end
  end

  initial begin
    int n, r0, f0;
    bit found;

    // Reset with SW held high
    repeat (5) @(negedge CLK);
    check("rst_db", SW_DB, 0);
    check("rst_rise", SW_RISE, 0);
    check("rst_fall", SW_FALL, 0);
    check("rst_toggle", SW_TOGGLE, 0);
    RST = 1'b0;
    wait_pulse(1'b1, 200, n);
    check("rst_rise_lat", n, LAT);
    check("rst_rise_db", SW_DB, 1);
    check("rst_rise_tog", SW_TOGGLE, 1);
    @(negedge CLK);
    check("rst_rise_1cyc", SW_RISE, 0);

    // Clean fall then clean rise
    SW = 1'b0;
    wait_pulse(1'b0, 200, n);
    check("fall_lat", n, LAT);
    check("fall_db", SW_DB, 0);
    check("fall_tog", SW_TOGGLE, 1);
    SW = 1'b1;
    wait_pulse(1'b1, 200, n);
    check("step_lat", n, LAT);
    check("step_db", SW_DB, 1);
    check("step_tog", SW_TOGGLE, 0);
    @(negedge CLK);
    check("step_1cyc", SW_RISE, 0);
    SW = 1'b0;
    wait_pulse(1'b0, 200, n);
    check("step_fall_lat", n, LAT);

    // Bounce every 7 cycles
    r0 = rise_cnt; f0 = fall_cnt;
    for (int i = 0; i < 300; i++) begin
      if (i % 7 == 0) SW = ~SW;
      @(negedge CLK);
    end
    SW = 1'b0;
    repeat (80) @(negedge CLK);
    check("bounce_db", SW_DB, 0);
    check("bounce_rise", rise_cnt - r0, 0);
    check("bounce_fall", fall_cnt - f0, 0);

    // Near threshold: 49 cycles ignored, 50 accepted
    SW = 1'b1;
    repeat (CNT_MAX - 1) @(negedge CLK);
    SW = 1'b0;
    repeat (100) @(negedge CLK);
    check("near49_db", SW_DB, 0);
    check("near49_rise", rise_cnt - r0, 0);
    SW = 1'b1;
    repeat (CNT_MAX) @(negedge CLK);
    SW = 1'b0;
    repeat (5) @(negedge CLK);
    check("near50_rise", rise_cnt - r0, 1);
    check("near50_db", SW_DB, 1);
    repeat (100) @(negedge CLK);
    check("near50_fall", fall_cnt - f0, 1);
    check("near50_db_lo", SW_DB, 0);

    // Toggle over three presses from a fresh reset
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("tog_reset", SW_TOGGLE, 0);
    r0 = rise_cnt; f0 = fall_cnt;
    for (int k = 0; k < 3; k++) begin
      SW = 1'b1;
      repeat (80) @(negedge CLK);
      check($sformatf("tog_seq%0d", k), SW_TOGGLE, (k % 2 == 0) ? 1 : 0);
      SW = 1'b0;
      repeat (80) @(negedge CLK);
    end
    check("tog_rises", rise_cnt - r0, 3);
    check("tog_falls", fall_cnt - f0, 3);

    // Reset in the middle of a pending rise
    r0 = rise_cnt;
    SW = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      if (int'(dut.cnt_q) == 30) found = 1'b1;
    end
    check("mid_cnt_reached", int'(found), 1);
    check("mid_state_pend", int'(dut.state_q), int'(ST_PEND_HI));
    #2;
    RST = 1'b1;
    #1;
    check("mid_state_lo", int'(dut.state_q), int'(ST_LO));
    check("mid_cnt_zero", int'(dut.cnt_q), 0);
    check("mid_db", SW_DB, 0);
    @(negedge CLK);
    RST = 1'b0;
    SW  = 1'b0;
    repeat (100) @(negedge CLK);
    check("mid_no_pulse", rise_cnt - r0, 0);

    // Random switch activity
    r0 = rise_cnt; f0 = fall_cnt;
    for (int i = 0; i < 1000; i++) begin
      SW = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    SW = 1'b0;
    repeat (120) @(negedge CLK);
    check("rand_db_final", SW_DB, 0);
    check("rand_pairing", rise_cnt - r0, fall_cnt - f0);
    check("invariants", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
